// File: rtl/matrix_sequencer.sv
// Byte-command matrix sequencer: loads 64-bit frames from the Pi bus and plays them onto output_pin.
// Optional build macro MATRIX_SEQ_TIMEOUT_EN adds a 2^20-cycle mid-packet idle abort.
module matrix_sequencer #(
  parameter int NUM_FRAMES = 4,
  parameter int DWELL_W    = 16
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic [7:0]  RPI_IO,
  input  logic        write_strobe,
  output logic [63:0] output_pin,
  output logic        busy,
  output logic [1:0]  LED
);

  localparam int IDX_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [6:0]         NUM_FRAMES_C = 7'(NUM_FRAMES);
  localparam logic [IDX_W-1:0]   IDX_ZERO     = IDX_W'(0);
  localparam logic [IDX_W-1:0]   IDX_ONE      = IDX_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ZERO   = DWELL_W'(0);
  localparam logic [DWELL_W-1:0] DWELL_ONE    = DWELL_W'(1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_DWELL = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_CMD       = 2'd0,
    ST_LOADDATA  = 2'd1,
    ST_DWELLDATA = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic       strobe_meta_r, strobe_sync_r, strobe_prev_r;
  logic [7:0] data_meta_r, data_sync_r;
  logic       accept_s;
  logic [7:0] byte_s;
  logic       arg_ok_s;

  logic             load_start_s, load_byte_s, load_wr_s;
  logic             dwell_start_s, dwell_hi_wr_s, dwell_commit_s;
  logic             run_start_s, stop_s, err_set_s;
  logic [IDX_W-1:0] load_idx_r;
  logic             load_ok_r;
  logic [2:0]       load_cnt_r;
  logic             dwell_cnt_r;
  logic [7:0]       dwell_hi_r;
  logic [DWELL_W-1:0] dwell_r, hold_cnt_r, reload_s;

  logic [63:0]      frame_r [NUM_FRAMES];
  logic [63:0]      out_r;
  logic             run_r, err_r, busy_r;
  logic [IDX_W-1:0] cur_r, last_r, cur_nxt_s;
  logic             timeout_s;

  // Two-flop synchronizers for the Pi bus, plus strobe history for falling-edge detect
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      strobe_meta_r <= 1'b0;
      strobe_sync_r <= 1'b0;
      strobe_prev_r <= 1'b0;
      data_meta_r   <= 8'd0;
      data_sync_r   <= 8'd0;
    end else begin
      strobe_meta_r <= write_strobe;
      strobe_sync_r <= strobe_meta_r;
      strobe_prev_r <= strobe_sync_r;
      data_meta_r   <= RPI_IO;
      data_sync_r   <= data_meta_r;
    end
  end

  assign accept_s = strobe_prev_r & ~strobe_sync_r;
  assign byte_s   = data_sync_r;
  assign arg_ok_s = ({1'b0, byte_s[5:0]} < NUM_FRAMES_C);

`ifdef MATRIX_SEQ_TIMEOUT_EN
  logic [19:0] idle_cnt_r;

  assign timeout_s = (state_r != ST_CMD) && !accept_s && (idle_cnt_r == 20'hF_FFFF);

  // Idle counter for abandoned packets; only counts while a packet is open
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      idle_cnt_r <= 20'd0;
    end else if (accept_s || (state_r == ST_CMD) || timeout_s) begin
      idle_cnt_r <= 20'd0;
    end else begin
      idle_cnt_r <= idle_cnt_r + 20'd1;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Parser state register
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_r <= ST_CMD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Parser next-state and per-byte action strobes
  always_comb begin
    state_nxt_s    = state_r;
    load_start_s   = 1'b0;
    load_byte_s    = 1'b0;
    load_wr_s      = 1'b0;
    dwell_start_s  = 1'b0;
    dwell_hi_wr_s  = 1'b0;
    dwell_commit_s = 1'b0;
    run_start_s    = 1'b0;
    stop_s         = 1'b0;
    err_set_s      = 1'b0;
    case (state_r)
      ST_CMD: begin
        if (accept_s) begin
          case (byte_s[7:6])
            OP_LOAD: begin
              state_nxt_s  = ST_LOADDATA;
              load_start_s = 1'b1;
              err_set_s    = ~arg_ok_s;
            end
            OP_DWELL: begin
              state_nxt_s   = ST_DWELLDATA;
              dwell_start_s = 1'b1;
            end
            OP_RUN: begin
              run_start_s = arg_ok_s;
              err_set_s   = ~arg_ok_s;
            end
            OP_STOP: begin
              stop_s = 1'b1;
            end
            default: begin
              state_nxt_s = ST_CMD;
            end
          endcase
        end else begin
          state_nxt_s = ST_CMD;
        end
      end
      ST_LOADDATA: begin
        if (accept_s) begin
          load_byte_s = 1'b1;
          load_wr_s   = load_ok_r;
          if (load_cnt_r == 3'd7) begin
            state_nxt_s = ST_CMD;
          end else begin
            state_nxt_s = ST_LOADDATA;
          end
        end else if (timeout_s) begin
          state_nxt_s = ST_CMD;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_LOADDATA;
        end
      end
      ST_DWELLDATA: begin
        if (accept_s) begin
          if (dwell_cnt_r == 1'b0) begin
            dwell_hi_wr_s = 1'b1;
            state_nxt_s   = ST_DWELLDATA;
          end else begin
            dwell_commit_s = 1'b1;
            state_nxt_s    = ST_CMD;
          end
        end else if (timeout_s) begin
          // Partial dwell is dropped simply by never committing it
          state_nxt_s = ST_CMD;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_DWELLDATA;
        end
      end
      default: begin
        state_nxt_s = ST_CMD;
      end
    endcase
  end

  // Packet bookkeeping: target frame, byte lane counter, dwell high byte, dwell value
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      load_idx_r  <= IDX_ZERO;
      load_ok_r   <= 1'b0;
      load_cnt_r  <= 3'd0;
      dwell_cnt_r <= 1'b0;
      dwell_hi_r  <= 8'd0;
      dwell_r     <= DWELL_ONE;
    end else begin
      if (load_start_s) begin
        load_idx_r <= byte_s[IDX_W-1:0];
        load_ok_r  <= arg_ok_s;
        load_cnt_r <= 3'd0;
      end else if (load_byte_s) begin
        load_cnt_r <= load_cnt_r + 3'd1;
      end
      if (dwell_start_s) begin
        dwell_cnt_r <= 1'b0;
      end else if (dwell_hi_wr_s) begin
        dwell_hi_r  <= byte_s;
        dwell_cnt_r <= 1'b1;
      end
      if (dwell_commit_s) begin
        dwell_r <= DWELL_W'({dwell_hi_r, byte_s});
      end
    end
  end

  // Frame bank: each LOAD data byte fills one 8-bit lane
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        frame_r[f] <= 64'd0;
      end
    end else if (load_wr_s) begin
      frame_r[load_idx_r][{load_cnt_r, 3'b000} +: 8] <= byte_s;
    end
  end

  // A stored dwell of 0 behaves as 1 cycle per frame
  assign reload_s  = (dwell_r == DWELL_ZERO) ? DWELL_ZERO : (dwell_r - DWELL_ONE);
  assign cur_nxt_s = (cur_r == last_r) ? IDX_ZERO : (cur_r + IDX_ONE);

  // Playback engine; output_pin samples the frame bank before any same-cycle write
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      run_r      <= 1'b0;
      cur_r      <= IDX_ZERO;
      last_r     <= IDX_ZERO;
      hold_cnt_r <= DWELL_ZERO;
      out_r      <= 64'd0;
    end else if (run_start_s) begin
      run_r      <= 1'b1;
      cur_r      <= IDX_ZERO;
      last_r     <= byte_s[IDX_W-1:0];
      hold_cnt_r <= reload_s;
      out_r      <= frame_r[0];
    end else if (stop_s) begin
      run_r <= 1'b0;
      out_r <= 64'd0;
    end else if (run_r) begin
      if (hold_cnt_r == DWELL_ZERO) begin
        cur_r      <= cur_nxt_s;
        out_r      <= frame_r[cur_nxt_s];
        hold_cnt_r <= reload_s;
      end else begin
        hold_cnt_r <= hold_cnt_r - DWELL_ONE;
      end
    end
  end

  // Sticky error flag and registered busy indicator
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      err_r  <= err_r | err_set_s;
      busy_r <= (state_nxt_s != ST_CMD);
    end
  end

  assign output_pin = out_r;
  assign busy       = busy_r;
  assign LED        = {err_r, run_r};

endmodule

// File: tb/tb_matrix_sequencer.sv
// Scoreboard bench for matrix_sequencer: a per-cycle behavioural model predicts output_pin/LED/busy.
module tb_matrix_sequencer;
  localparam int NF = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  RPI_IO = 8'd0;
  logic        write_strobe = 1'b1;
  logic [63:0] output_pin;
  logic        busy;
  logic [1:0]  LED;

  matrix_sequencer #(.NUM_FRAMES(NF), .DWELL_W(16)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .RPI_IO(RPI_IO), .write_strobe(write_strobe),
    .output_pin(output_pin), .busy(busy), .LED(LED)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct { int at; logic [7:0] b; } ev_t;
  typedef struct { logic [63:0] pin; logic [1:0] led; logic busy; } exp_t;
  ev_t  ev_q[$];
  exp_t exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state, expressed as "frame on show until cycle switch_at"
  logic [63:0] m_frame [NF];
  int          m_dwell, m_cur, m_last, m_switch_at, m_mode, m_cnt, m_idx;
  bit          m_run, m_err, m_ok;
  logic [63:0] m_out;
  logic [7:0]  m_hi;

  function automatic int eff_dwell(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < NF; f++) m_frame[f] = 64'd0;
    m_dwell = 1; m_cur = 0; m_last = 0; m_switch_at = 0;
    m_mode = 0; m_cnt = 0; m_idx = 0; m_run = 0; m_err = 0; m_ok = 0;
    m_out = 64'd0; m_hi = 8'd0;
  endtask

  task automatic model_step();
    bit have_b;
    logic [7:0] b;
    int arg;
    have_b = 0;
    b = 8'd0;
    while (ev_q.size() > 0 && ev_q[0].at < cyc) void'(ev_q.pop_front());
    if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
      b = ev_q[0].b;
      have_b = 1;
      void'(ev_q.pop_front());
    end
    arg = int'(b[5:0]);
    // playback decisions use the frame contents from before this byte
    if (have_b && m_mode == 0 && b[7:6] == 2'b10) begin
      if (arg < NF) begin
        m_run = 1; m_cur = 0; m_last = arg; m_out = m_frame[0];
        m_switch_at = cyc + eff_dwell(m_dwell);
      end else begin
        m_err = 1;
      end
    end else if (have_b && m_mode == 0 && b[7:6] == 2'b11) begin
      m_run = 0; m_out = 64'd0;
    end else if (m_run && cyc == m_switch_at) begin
      m_cur = (m_cur == m_last) ? 0 : m_cur + 1;
      m_out = m_frame[m_cur];
      m_switch_at = cyc + eff_dwell(m_dwell);
    end
    if (have_b) begin
      if (m_mode == 0) begin
        if (b[7:6] == 2'b00) begin
          m_mode = 1; m_cnt = 0; m_idx = arg; m_ok = (arg < NF);
          if (!m_ok) m_err = 1;
        end else if (b[7:6] == 2'b01) begin
          m_mode = 2; m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (m_ok) m_frame[m_idx][8*m_cnt +: 8] = b;
        m_cnt++;
        if (m_cnt == 8) m_mode = 0;
      end else begin
        if (m_cnt == 0) begin
          m_hi = b; m_cnt = 1;
        end else begin
          m_dwell = int'({m_hi, b});
          m_mode = 0;
        end
      end
    end
  endtask

  // Model: one expectation per rising edge
  initial begin
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk_100mhz);
      cyc++;
      if (rst) model_reset();
      else model_step();
      e.pin = m_out; e.led = {m_err, m_run}; e.busy = (m_mode != 0);
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100mhz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (output_pin !== e.pin || LED !== e.led || busy !== e.busy) begin
          n_fail++;
          $display("FAIL scoreboard cyc=%0d got pin=%h led=%b busy=%b want pin=%h led=%b busy=%b",
                   cyc, output_pin, LED, busy, e.pin, e.led, e.busy);
        end
      end
    end
  end

  task automatic check_now(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ev_t ev;
    @(posedge clk_100mhz);
    #1;
    RPI_IO = b;
    write_strobe = 1'b0;
    ev.at = cyc + 3; ev.b = b;
    ev_q.push_back(ev);
    repeat (2) @(posedge clk_100mhz);
    #1 write_strobe = 1'b1;
    repeat (2) @(posedge clk_100mhz);
  endtask

  task automatic send_load(input logic [7:0] hdr, input logic [63:0] data);
    send_byte(hdr);
    for (int k = 0; k < 8; k++) send_byte(data[8*k +: 8]);
  endtask

  task automatic do_reset();
    @(posedge clk_100mhz);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk_100mhz);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_100mhz);
  endtask

  initial begin
    int op;
    repeat (3) @(posedge clk_100mhz);
    #1 rst = 1'b0;
    idle(100);
    @(negedge clk_100mhz);
    check_now("idle_pin", output_pin, 64'd0);

    // frame 0 = 01..08, dwell 3, run last=0
    send_load(8'h00, 64'h0807060504030201);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h80);
    @(negedge clk_100mhz);
    check_now("run0_pin", output_pin, 64'h0807060504030201);
    check_now("run0_led", {62'd0, LED}, 64'd1);
    idle(12);

    // two frames alternating with dwell 5, then stop
    send_load(8'h00, {8{8'h11}});
    send_load(8'h01, {8{8'h22}});
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h81);
    idle(20);
    send_byte(8'hC0);
    @(negedge clk_100mhz);
    check_now("stop_pin", output_pin, 64'd0);
    check_now("stop_led0", {63'd0, LED[0]}, 64'd0);

    // out-of-range RUN and LOAD
    send_byte(8'h81);
    idle(7);
    send_byte(8'h84);
    @(negedge clk_100mhz);
    check_now("badrun_err", {63'd0, LED[1]}, 64'd1);
    check_now("badrun_run", {63'd0, LED[0]}, 64'd1);
    send_load(8'h05, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk_100mhz);
    check_now("badload_busy", {63'd0, busy}, 64'd0);

    // reset in the middle of a LOAD
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hAA);
    do_reset();
    @(negedge clk_100mhz);
    check_now("rst_busy", {63'd0, busy}, 64'd0);
    send_byte(8'h80);
    @(negedge clk_100mhz);
    check_now("rst_run_pin", output_pin, 64'd0);
    idle(5);

    // randomized packet mix
    do_reset();
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        send_load({2'b00, 6'($urandom_range(0, 5))}, {$urandom, $urandom});
      end else if (op < 6) begin
        send_byte(8'h40); send_byte(8'h00); send_byte(8'($urandom_range(0, 6)));
      end else if (op < 9) begin
        send_byte({2'b10, 6'($urandom_range(0, 4))});
      end else begin
        send_byte(8'hC0);
      end
      idle($urandom_range(0, 15));
    end
    idle(10);
    check_now("events_drained", 64'(ev_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_sequencer.md
Name: matrix_sequencer

Overview:
Command-driven controller that owns the 64-pin matrix output. It receives byte packets from the Raspberry Pi over the 8-bit RPI_IO bus, qualified by write_strobe. The packets load a small bank of 64-bit frames, set a dwell time, and start or stop playback. Playback cycles the frames onto output_pin, each held for a programmable number of clk_100mhz cycles.

Parameters:
NUM_FRAMES, 4, number of 64-bit frame registers (2..64)
DWELL_W, 16, width of the dwell counter in clock cycles

Ports:
clk_100mhz  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
RPI_IO  input  8  command/data byte from the Raspberry Pi, asynchronous
write_strobe  input  1  byte strobe from the Raspberry Pi, asynchronous; byte taken on falling edge
output_pin  output  64  registered matrix drive
busy  output  1  high while the parser is mid-packet (state not CMD)
LED  output  2  LED[0] = running, LED[1] = sticky error

Behaviour:
- Clocking: one clock (clk_100mhz); reset is synchronous and active-high (rst).
- Reset values:
  - output_pin = 0, LED = 0, busy = 0.
  - All frames = 0, dwell = 1, run = 0, parser state = CMD.
  - Strobe synchronizer and edge flops = 0.
- Input capture:
  - write_strobe passes through 2 synchronizer flops plus 1 edge flop.
  - RPI_IO passes through 2 synchronizer flops.
  - A byte is accepted in the cycle where the synced strobe is 0 and the edge flop is 1.
  - The accepted byte is the synced RPI_IO value in that cycle.
  - At most one byte per falling edge.
  - Effective latency is 3 cycles from the pin falling edge.
- Command byte: bits [7:6] = opcode, bits [5:0] = arg.
  - 00 LOAD: arg = frame index; 8 data bytes follow. Data byte k (k = 0..7) writes frame[arg][8k+7:8k].
  - 01 DWELL: 2 data bytes follow, high byte first. Sets dwell[DWELL_W-1:0]; bits above DWELL_W are dropped. A dwell of 0 is treated as 1.
  - 10 RUN: arg = last frame index. Playback restarts at frame 0 and cycles 0..last.
  - 11 STOP: run cleared; output_pin becomes 0 on the next cycle.
- Parser states:
  - CMD: a LOAD byte moves to LOADDATA (byte count = 0); a DWELL byte moves to DWELLDATA (count = 0). RUN and STOP execute in the accepting cycle and stay in CMD.
  - LOADDATA: on each accepted byte, write the byte and increment the count. After the 8th byte, return to CMD.
  - DWELLDATA: after the 2nd byte, commit the 16-bit value and return to CMD. The new dwell takes effect at the next counter reload; a running frame is not truncated.
- Error handling:
  - A LOAD or RUN whose arg is NUM_FRAMES or greater sets LED[1].
  - A bad LOAD still consumes its 8 data bytes but writes nothing. A bad RUN is ignored and the run state is unchanged.
  - LED[1] is cleared only by rst.
- Playback:
  - A valid RUN sets cur = 0, last = arg, count = dwell-1 and run = 1. output_pin = frame[0] is visible on the cycle after the RUN byte is accepted.
  - While run = 1: if count = 0, cur advances to (cur == last ? 0 : cur+1), output_pin loads the new frame, and count reloads dwell-1. Otherwise count decrements.
  - Result: each frame is held exactly max(dwell,1) cycles.
  - last = 0 holds frame 0 continuously.
  - LED[0] = run.
- Simultaneous events:
  - RUN while running restarts from frame 0 with the new last.
  - A LOAD write to the frame being switched in during the same cycle: output_pin takes the pre-write contents; the new data appears at that frame's next display.
  - Writes to a frame on display do not alter output_pin until its next switch.
  - rst mid-packet discards the partial packet and returns to reset values.

Optional Feature:
Macro MATRIX_SEQ_TIMEOUT_EN.
- Defined: a 20-bit idle counter runs while the state is not CMD and clears on every accepted byte. At 2^20 cycles (~10.5 ms) it aborts the packet:
  - parser returns to CMD;
  - already-written LOAD bytes remain;
  - a partial DWELL is discarded;
  - LED[1] is set.
- Not defined: the parser waits indefinitely for the remaining packet bytes; no counter logic exists.

Test Plan:
- Reset, then no strobes -> output_pin = 0, LED = 00, busy = 0 for 100 cycles.
- LOAD frame 0 with bytes 01..08, DWELL 0x0003, RUN arg 0 -> output_pin = 0x0807060504030201 one cycle after the RUN accept and held; LED[0] = 1.
- Load frame 0 = all 0x11 and frame 1 = all 0x22, DWELL 0x0005, RUN arg 1 -> output_pin alternates 0x1111..11 / 0x2222..22, exactly 5 cycles each, for 20 cycles; then STOP -> output_pin = 0 on the next cycle, LED[0] = 0.
- RUN arg 4 with NUM_FRAMES = 4 -> LED[1] = 1 and playback state unchanged. LOAD arg 5 plus 8 bytes -> no frame modified, busy falls after the 8th byte.
- Assert rst after 3 of 8 LOAD data bytes -> busy = 0, frames = 0. The next byte 0x80 (RUN arg 0) is accepted as a command, giving output_pin = 0.
- With MATRIX_SEQ_TIMEOUT_EN: send a LOAD header plus 2 bytes, then idle 2^20 cycles -> busy = 0, LED[1] = 1, and a following RUN is accepted.
